// File: rtl/rtc_pkg.sv
// Shared RTC timebase constants and the saturating clamp used for the
// calibrated second length.
package rtc_pkg;

  localparam int RTC_BASE_FREQ   = 10_000_000;
  localparam int RTC_PRE_LOG2    = 7;
  localparam int RTC_DEFAULT_DIV = RTC_BASE_FREQ / (2 ** RTC_PRE_LOG2);
  localparam int RTC_CALC_W      = 34;

  // A second shorter than 2 ticks would leave no room for the terminal compare.
  function automatic logic [31:0] rtc_clamp(input logic signed [RTC_CALC_W-1:0] val,
                                            input logic [31:0] hi);
    logic signed [RTC_CALC_W-1:0] hi_s;
    hi_s = $signed({2'b00, hi});
    if (val < 34'sd2)
      return 32'd2;
    else if (val > hi_s)
      return hi;
    else
      return val[31:0];
  endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchroniser for an asynchronous trigger followed by a rising-edge
// pulse; no edge is reported until the edge-detect flop holds a real sample.
module trig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic edge_p
);

  logic [2:0] sync_q;
  logic [2:0] arm_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], trig};
      arm_q  <= {arm_q[1:0], 1'b1};
    end
  end

  // arm_q[2] masks the level held through reset release from looking like an edge.
  assign edge_p = arm_q[2] & sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/rtc_prescaler.sv
// RTC timebase: trigger edges -> prescaler ticks -> calibrated 1 Hz pulse and
// 0.5 Hz square wave, with a shadowed runtime divisor.
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int PRE_LOG2    = RTC_PRE_LOG2,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = RTC_DEFAULT_DIV,
  parameter int CAL_W       = 8,
  parameter int CAL_PERIOD  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig,
  input  logic                  en,
  input  logic                  div_load,
  input  logic [DIV_W-1:0]      div_val,
  input  logic [CAL_W-1:0]      cal_val,
  output logic                  tick,
  output logic                  one_hz,
  output logic                  half_hz_50,
  output logic [(CAL_PERIOD > 1 ? $clog2(CAL_PERIOD) : 1)-1:0] cal_phase
);

  localparam int          CP_W     = (CAL_PERIOD > 1) ? $clog2(CAL_PERIOD) : 1;
  localparam logic [31:0] TERM_MAX = 32'((64'd1 << DIV_W) - 64'd1);

  logic                    edge_p;
  logic [PRE_LOG2-1:0]     pre_cnt;
  logic [DIV_W-1:0]        sec_cnt;
  logic [DIV_W-1:0]        div_active;
  logic [DIV_W-1:0]        div_pend;
  logic                    pend_vld;
  logic [DIV_W-1:0]        term;
  logic [DIV_W-1:0]        load_val;
  logic signed [DIV_W+1:0] trim;
  logic signed [DIV_W+1:0] term_sum;
  logic                    wrap;
  logic                    is_cal;
  logic                    last_sec;
  logic                    roll;

  trig_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .trig   (trig),
    .edge_p (edge_p)
  );

  // The trim only lengthens or shortens the last second of each cal cycle.
  assign wrap     = edge_p & en & (&pre_cnt);
  assign is_cal   = (cal_phase == CP_W'(CAL_PERIOD - 1));
  assign trim     = is_cal ? (DIV_W+2)'($signed(cal_val)) : '0;
  assign term_sum = $signed({2'b00, div_active}) + trim;
  assign term     = DIV_W'(rtc_clamp(RTC_CALC_W'(term_sum), TERM_MAX));
  assign last_sec = (sec_cnt == term - DIV_W'(1));
  assign roll     = wrap & last_sec;
  assign load_val = (div_val < DIV_W'(2)) ? DIV_W'(2) : div_val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt    <= '0;
      sec_cnt    <= '0;
      div_active <= DIV_W'(DEFAULT_DIV);
      div_pend   <= '0;
      pend_vld   <= 1'b0;
      tick       <= 1'b0;
      one_hz     <= 1'b0;
      half_hz_50 <= 1'b0;
      cal_phase  <= '0;
    end else begin
      tick   <= wrap;
      one_hz <= roll;
      if (edge_p && en)
        pre_cnt <= pre_cnt + PRE_LOG2'(1);
      if (wrap)
        sec_cnt <= last_sec ? '0 : sec_cnt + DIV_W'(1);
      if (roll) begin
        half_hz_50 <= ~half_hz_50;
        cal_phase  <= is_cal ? '0 : cal_phase + CP_W'(1);
        if (pend_vld) begin
          div_active <= div_pend;
          pend_vld   <= 1'b0;
        end
      end
      // A load in the rollover cycle lands after the swap, so it waits one more second.
      if (div_load) begin
        div_pend <= load_val;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_prescaler.sv
// Directed self-checking bench for rtc_prescaler with small parameters
// (4 trig rises per tick, 5 ticks per second, 4-second cal cycle).
module tb_rtc_prescaler;

  localparam int DIV_W       = 8;
  localparam int CAL_W       = 8;
  localparam int PRE_LOG2    = 2;
  localparam int DEFAULT_DIV = 5;
  localparam int CAL_PERIOD  = 4;

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic             trig     = 1'b0;
  logic             en       = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_val  = '0;
  logic [CAL_W-1:0] cal_val  = '0;
  logic             tick;
  logic             one_hz;
  logic             half_hz_50;
  logic [1:0]       cal_phase;

  int n_cmp    = 0;
  int n_err    = 0;
  int rise_cnt = 0;
  int tick_cnt = 0;
  int wide_cnt = 0;
  int         oh_rise[$];
  logic       oh_half[$];
  logic [1:0] oh_phase[$];
  logic       one_hz_prev = 1'b0;

  always #5 clk = ~clk;

  rtc_prescaler #(
    .PRE_LOG2    (PRE_LOG2),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .CAL_W       (CAL_W),
    .CAL_PERIOD  (CAL_PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .en         (en),
    .div_load   (div_load),
    .div_val    (div_val),
    .cal_val    (cal_val),
    .tick       (tick),
    .one_hz     (one_hz),
    .half_hz_50 (half_hz_50),
    .cal_phase  (cal_phase)
  );

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (tick) tick_cnt++;
    if (one_hz) begin
      oh_rise.push_back(rise_cnt);
      oh_half.push_back(half_hz_50);
      oh_phase.push_back(cal_phase);
    end
    if (one_hz && one_hz_prev) wide_cnt++;
    one_hz_prev = one_hz;
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      trig = 1'b1;
      rise_cnt++;
      step(4);
      trig = 1'b0;
      step(4);
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int rollAt(input int idx);
    return (idx < oh_rise.size()) ? oh_rise[idx] : -1;
  endfunction

  task automatic doReset();
    rst      = 1'b0;
    trig     = 1'b0;
    en       = 1'b1;
    div_load = 1'b0;
    cal_val  = '0;
    step(3);
    rst = 1'b1;
    step(5);
    rise_cnt = 0;
  endtask

  initial begin
    int base;
    int t0;
    int w0;
    int exp3a[4] = '{20, 40, 60, 88};
    int exp3b[5] = '{20, 40, 60, 68, 88};
    int exp4[8]  = '{20, 32, 40, 64, 88, 112, 136, 148};

    // 1: reset with trig toggling, then first second from reset
    rst = 1'b0;
    en  = 1'b1;
    trig = 1'b1; step(1);
    trig = 1'b0; step(1);
    trig = 1'b1; step(1);
    checkOutput("t1_rst_tick", int'(tick), 0);
    checkOutput("t1_rst_one_hz", int'(one_hz), 0);
    checkOutput("t1_rst_half", int'(half_hz_50), 0);
    checkOutput("t1_rst_phase", int'(cal_phase), 0);
    trig = 1'b0;
    step(1);
    rst = 1'b1;
    step(5);
    rise_cnt = 0;
    t0 = tick_cnt;
    base = oh_rise.size();
    applyStimulus(19);
    checkOutput("t1_ticks_19", tick_cnt - t0, 4);
    checkOutput("t1_no_early_1hz", oh_rise.size() - base, 0);
    trig = 1'b1;
    rise_cnt++;
    step(1);
    checkOutput("t1_clk1_one_hz", int'(one_hz), 0);
    step(1);
    checkOutput("t1_clk2_one_hz", int'(one_hz), 0);
    step(1);
    checkOutput("t1_clk3_one_hz", int'(one_hz), 1);
    checkOutput("t1_clk3_tick", int'(tick), 1);
    checkOutput("t1_clk3_half", int'(half_hz_50), 1);
    checkOutput("t1_clk3_phase", int'(cal_phase), 1);
    step(1);
    checkOutput("t1_clk4_one_hz", int'(one_hz), 0);
    trig = 1'b0;
    step(4);
    checkOutput("t1_ticks_20", tick_cnt - t0, 5);

    // 2: steady state, 60 rises
    doReset();
    base = oh_rise.size();
    w0 = wide_cnt;
    applyStimulus(60);
    checkOutput("t2_count", oh_rise.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t2_rise%0d", i), rollAt(base + i), 20 * (i + 1));
      if (base + i < oh_half.size()) begin
        checkOutput($sformatf("t2_half%0d", i), int'(oh_half[base + i]), (i == 1) ? 0 : 1);
        checkOutput($sformatf("t2_phase%0d", i), int'(oh_phase[base + i]), i + 1);
      end
    end
    checkOutput("t2_pulse_width", wide_cnt - w0, 0);

    // 3: positive trim, then negative trim clamped to 2 ticks
    doReset();
    cal_val = 8'd2;
    base = oh_rise.size();
    applyStimulus(88);
    checkOutput("t3a_count", oh_rise.size() - base, 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t3a_rise%0d", i), rollAt(base + i), exp3a[i]);
    cal_val = 8'hF6;
    rise_cnt = 0;
    base = oh_rise.size();
    applyStimulus(88);
    checkOutput("t3b_count", oh_rise.size() - base, 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t3b_rise%0d", i), rollAt(base + i), exp3b[i]);
    cal_val = '0;

    // 4: divisor loads, min clamp, last-wins, load on rollover cycle
    doReset();
    base = oh_rise.size();
    applyStimulus(8);
    div_val = 8'd3; div_load = 1'b1; step(1); div_load = 1'b0;
    applyStimulus(16);
    div_val = 8'd0; div_load = 1'b1; step(1); div_load = 1'b0;
    applyStimulus(9);
    div_val = 8'd3; div_load = 1'b1; step(1);
    div_val = 8'd6; step(1); div_load = 1'b0;
    applyStimulus(55);
    applyStimulus(23);
    trig = 1'b1;
    rise_cnt++;
    step(2);
    div_val = 8'd3; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    checkOutput("t4_roll_load_pulse", int'(one_hz), 1);
    trig = 1'b0;
    step(5);
    applyStimulus(36);
    checkOutput("t4_count", oh_rise.size() - base, 8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t4_rise%0d", i), rollAt(base + i), exp4[i]);

    // 5: enable gap discards edges
    doReset();
    base = oh_rise.size();
    applyStimulus(10);
    en = 1'b0;
    t0 = tick_cnt;
    applyStimulus(7);
    checkOutput("t5_gap_ticks", tick_cnt - t0, 0);
    checkOutput("t5_gap_one_hz", oh_rise.size() - base, 0);
    checkOutput("t5_gap_half", int'(half_hz_50), 0);
    checkOutput("t5_gap_phase", int'(cal_phase), 0);
    en = 1'b1;
    applyStimulus(10);
    checkOutput("t5_count", oh_rise.size() - base, 1);
    checkOutput("t5_rise", rollAt(base), 27);
    checkOutput("t5_half_after", int'(half_hz_50), 1);

    // 6: reset mid-second with a pending load and trig high across release
    doReset();
    applyStimulus(10);
    div_val = 8'd3; div_load = 1'b1; step(1); div_load = 1'b0;
    applyStimulus(4);
    trig = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    t0 = tick_cnt;
    base = oh_rise.size();
    step(6);
    checkOutput("t6_tick", int'(tick), 0);
    checkOutput("t6_half", int'(half_hz_50), 0);
    checkOutput("t6_phase", int'(cal_phase), 0);
    checkOutput("t6_no_edge_on_release", tick_cnt - t0, 0);
    trig = 1'b0;
    step(4);
    rise_cnt = 0;
    applyStimulus(20);
    checkOutput("t6_ticks_20", tick_cnt - t0, 5);
    applyStimulus(20);
    checkOutput("t6_count", oh_rise.size() - base, 2);
    checkOutput("t6_rise0", rollAt(base), 20);
    checkOutput("t6_rise1", rollAt(base + 1), 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
